// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_pkg
// Description : Shared cache geometry defaults, the scrub FSM state type and
//               the 28-bit SEC-DED (extended Hamming, 7 check bits) encoder.
//
//               Code layout: the codeword positions run from 1 to 34. The
//               power-of-two positions (1,2,4,8,16,32) carry Hamming bits
//               ecc[5:0]. The 28 data bits fill the remaining positions in
//               ascending order. ecc[6] is the overall parity of the data bits
//               and ecc[5:0], so a clean codeword has even parity.
// Revision    : 1.0 - initial release
// ============================================================================
package cache_pkg;

    localparam int CACHE_WAY_N = 4;
    localparam int CACHE_IDX_W = 6;
    localparam int CACHE_TAG_W = 28;
    localparam int TAG_ECC_W   = 7;

    typedef enum logic [0:0] {
        SCRUB_IDLE = 1'b0,
        SCRUB_REQ  = 1'b1
    } scrub_state_e;

    // Codeword position of data bit bit_i. The nth non-power-of-two
    // position in the range 1 to 34 holds data bit n.
    function automatic logic [5:0] sec_ded_pos(input int unsigned bit_i);
        logic [5:0]  pos;
        int unsigned n;
        pos = '0;
        n   = 0;
        for (int p = 1; p <= 34; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (n == bit_i) begin
                    pos = 6'(p);
                end
                n++;
            end
        end
        return pos;
    endfunction

    // Hamming bit k is the XOR of every data bit whose position has bit k set.
    function automatic logic [5:0] sec_ded_hamming_28(input logic [27:0] data);
        logic [5:0] h;
        logic [5:0] pos;
        h = '0;
        for (int i = 0; i < 28; i++) begin
            pos = sec_ded_pos(i);
            h   = h ^ (pos & {6{data[i]}});
        end
        return h;
    endfunction

    function automatic logic [6:0] sec_ded_encoder_28(input logic [27:0] data);
        logic [5:0] h;
        h = sec_ded_hamming_28(data);
        return {^{data, h}, h};
    endfunction

endpackage
`default_nettype wire

// File: rtl/sec_ded_decoder_28.sv
`default_nettype none
// ============================================================================
// Module      : sec_ded_decoder_28
// Description : Combinational SEC-DED decoder for a 28-bit word and its 7
//               check bits. It corrects any single-bit error, in the data or
//               in the check bits, and detects double-bit errors. On a double
//               error data_o returns the raw data.
// Ports       : data_i [27:0]  raw data
//               ecc_i  [6:0]   stored check bits
//               data_o [27:0]  corrected data
//               sbe_o          single-bit error seen (corrected)
//               dbe_o          uncorrectable error seen
// Revision    : 1.0 - initial release
// ============================================================================
module sec_ded_decoder_28
    import cache_pkg::*;
(
    input  logic [27:0] data_i,
    input  logic [6:0]  ecc_i,
    output logic [27:0] data_o,
    output logic        sbe_o,
    output logic        dbe_o
);

    logic [5:0] syn;
    logic       parity_err;
    logic       syn_in_range;

    always_comb begin
        syn          = sec_ded_hamming_28(data_i) ^ ecc_i[5:0];
        parity_err   = ^{data_i, ecc_i};
        // A single flip always points inside the 34-bit codeword. A larger
        // syndrome with odd parity can only come from three or more flips,
        // so it is reported as uncorrectable.
        syn_in_range = (syn <= 6'd34);
        sbe_o        = parity_err & syn_in_range;
        dbe_o        = (~parity_err & (syn != 6'd0)) | (parity_err & ~syn_in_range);

        data_o = data_i;
        for (int i = 0; i < 28; i++) begin
            if (sbe_o && (syn == sec_ded_pos(i))) begin
                data_o[i] = ~data_i[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/tag_ecc_check.sv
`default_nettype none
// ============================================================================
// Module      : tag_ecc_check
// Description : Checks the SEC-DED code on cache tags. A lookup at cycle N
//               gives corrected tags and per-way error flags at cycle N+1.
//               The block keeps saturating SBE and DBE counters. As an
//               option, it writes corrected tags back to the tag array
//               through a scrub handshake, one way at a time.
// Macro       : TAG_SCRUB_EN - when defined, the scrub FSM is built. When it
//               is not defined, the scrub outputs are tied to zero.
// Ports       : clk, rst (async, active-high)
//               lkup_valid_i/lkup_idx_i/lkup_way_i  tag read request
//               tag_rd_i/tag_ecc_rd_i               raw tag + check bits per way
//               chk_valid_o/chk_tag_o/chk_sbe_o/chk_dbe_o  check result
//               scrub_req_*                         scrub write handshake
//               scrub_busy_o/scrub_drop_o           scrub status
//               sbe_cnt_o/dbe_cnt_o                 saturating error counters
// Revision    : 1.0 - initial release
// ============================================================================
module tag_ecc_check
    import cache_pkg::*;
#(
    parameter int WAY_N = CACHE_WAY_N,
    parameter int IDX_W = CACHE_IDX_W,
    parameter int TAG_W = CACHE_TAG_W,
    parameter int ECC_W = TAG_ECC_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        lkup_valid_i,
    input  logic [IDX_W-1:0]            lkup_idx_i,
    input  logic [WAY_N-1:0]            lkup_way_i,
    input  logic [WAY_N-1:0][TAG_W-1:0] tag_rd_i,
    input  logic [WAY_N-1:0][ECC_W-1:0] tag_ecc_rd_i,
    output logic                        chk_valid_o,
    output logic [WAY_N-1:0][TAG_W-1:0] chk_tag_o,
    output logic [WAY_N-1:0]            chk_sbe_o,
    output logic [WAY_N-1:0]            chk_dbe_o,
    output logic                        scrub_req_valid_o,
    input  logic                        scrub_req_ready_i,
    output logic [IDX_W-1:0]            scrub_req_idx_o,
    output logic [WAY_N-1:0]            scrub_req_way_o,
    output logic [TAG_W-1:0]            scrub_req_tag_o,
    output logic                        scrub_busy_o,
    output logic                        scrub_drop_o,
    output logic [15:0]                 sbe_cnt_o,
    output logic [15:0]                 dbe_cnt_o
);

    // ------------------------------------------------------------------
    // Lookup pipeline: the tag array returns data one cycle after the read
    // ------------------------------------------------------------------
    logic             lkup_valid_d, lkup_valid_q;
    logic [IDX_W-1:0] lkup_idx_d,   lkup_idx_q;
    logic [WAY_N-1:0] lkup_way_d,   lkup_way_q;

    always_comb begin
        lkup_valid_d = lkup_valid_i;
        lkup_idx_d   = lkup_idx_i;
        lkup_way_d   = lkup_way_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lkup_valid_q <= 1'b0;
            lkup_idx_q   <= '0;
            lkup_way_q   <= '0;
        end else begin
            lkup_valid_q <= lkup_valid_d;
            lkup_idx_q   <= lkup_idx_d;
            lkup_way_q   <= lkup_way_d;
        end
    end

    assign chk_valid_o = lkup_valid_q;

    // ------------------------------------------------------------------
    // Per-way decode. Ways that are not enabled pass the raw tag through
    // and do not raise flags.
    // ------------------------------------------------------------------
    logic [WAY_N-1:0][TAG_W-1:0] dec_tag;
    logic [WAY_N-1:0]            dec_sbe;
    logic [WAY_N-1:0]            dec_dbe;
    logic [WAY_N-1:0]            way_en;

    for (genvar w = 0; w < WAY_N; w++) begin : g_way
        sec_ded_decoder_28 u_dec (
            .data_i (tag_rd_i[w]),
            .ecc_i  (tag_ecc_rd_i[w]),
            .data_o (dec_tag[w]),
            .sbe_o  (dec_sbe[w]),
            .dbe_o  (dec_dbe[w])
        );

        assign way_en[w]    = lkup_valid_q & lkup_way_q[w];
        assign chk_sbe_o[w] = way_en[w] & dec_sbe[w];
        assign chk_dbe_o[w] = way_en[w] & dec_dbe[w];
        assign chk_tag_o[w] = way_en[w] ? dec_tag[w] : tag_rd_i[w];
    end

    // ------------------------------------------------------------------
    // Error counters. Each one adds the popcount of its flag vector and
    // clips at 0xFFFF.
    // ------------------------------------------------------------------
    function automatic logic [15:0] sat_add(input logic [15:0] cnt,
                                            input logic [WAY_N-1:0] flags);
        logic [16:0] sum;
        sum = {1'b0, cnt};
        for (int w = 0; w < WAY_N; w++) begin
            sum = sum + 17'(flags[w]);
        end
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    logic [15:0] sbe_cnt_d, sbe_cnt_q;
    logic [15:0] dbe_cnt_d, dbe_cnt_q;

    always_comb begin
        sbe_cnt_d = sbe_cnt_q;
        dbe_cnt_d = dbe_cnt_q;
        if (chk_valid_o) begin
            sbe_cnt_d = sat_add(sbe_cnt_q, chk_sbe_o);
            dbe_cnt_d = sat_add(dbe_cnt_q, chk_dbe_o);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sbe_cnt_q <= '0;
            dbe_cnt_q <= '0;
        end else begin
            sbe_cnt_q <= sbe_cnt_d;
            dbe_cnt_q <= dbe_cnt_d;
        end
    end

    assign sbe_cnt_o = sbe_cnt_q;
    assign dbe_cnt_o = dbe_cnt_q;

`ifdef TAG_SCRUB_EN
    // ------------------------------------------------------------------
    // Scrub FSM. Only the SBE mask is latched, so a DBE way is never
    // written back. While a scrub is pending, new SBE results are dropped.
    // ------------------------------------------------------------------
    scrub_state_e                state_d,     state_q;
    logic [WAY_N-1:0]            pend_mask_d, pend_mask_q;
    logic [IDX_W-1:0]            pend_idx_d,  pend_idx_q;
    logic [WAY_N-1:0][TAG_W-1:0] pend_tag_d,  pend_tag_q;
    logic [WAY_N-1:0]            sel_way;
    logic [TAG_W-1:0]            sel_tag;
    logic                        busy;

    always_comb begin
        // The downward scan leaves the lowest pending way as the winner.
        sel_way = '0;
        for (int w = WAY_N - 1; w >= 0; w--) begin
            if (pend_mask_q[w]) begin
                sel_way    = '0;
                sel_way[w] = 1'b1;
            end
        end
        sel_tag = '0;
        for (int w = 0; w < WAY_N; w++) begin
            if (sel_way[w]) begin
                sel_tag = pend_tag_q[w];
            end
        end

        state_d     = state_q;
        pend_mask_d = pend_mask_q;
        pend_idx_d  = pend_idx_q;
        pend_tag_d  = pend_tag_q;

        case (state_q)
            SCRUB_IDLE: begin
                if (chk_valid_o && (|chk_sbe_o)) begin
                    pend_mask_d = chk_sbe_o;
                    pend_idx_d  = lkup_idx_q;
                    pend_tag_d  = chk_tag_o;
                    state_d     = SCRUB_REQ;
                end
            end
            SCRUB_REQ: begin
                if (scrub_req_ready_i) begin
                    pend_mask_d = pend_mask_q & ~sel_way;
                    if (pend_mask_d == '0) begin
                        state_d = SCRUB_IDLE;
                    end
                end
            end
            default: begin
                state_d = SCRUB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= SCRUB_IDLE;
            pend_mask_q <= '0;
            pend_idx_q  <= '0;
            pend_tag_q  <= '0;
        end else begin
            state_q     <= state_d;
            pend_mask_q <= pend_mask_d;
            pend_idx_q  <= pend_idx_d;
            pend_tag_q  <= pend_tag_d;
        end
    end

    assign busy              = (state_q == SCRUB_REQ);
    assign scrub_busy_o      = busy;
    assign scrub_req_valid_o = busy & (|pend_mask_q);
    assign scrub_req_idx_o   = scrub_req_valid_o ? pend_idx_q : '0;
    assign scrub_req_way_o   = scrub_req_valid_o ? sel_way    : '0;
    assign scrub_req_tag_o   = scrub_req_valid_o ? sel_tag    : '0;
    assign scrub_drop_o      = busy & chk_valid_o & (|chk_sbe_o);
`else
    logic unused_scrub;
    assign unused_scrub      = ^{scrub_req_ready_i, lkup_idx_q};

    assign scrub_req_valid_o = 1'b0;
    assign scrub_req_idx_o   = '0;
    assign scrub_req_way_o   = '0;
    assign scrub_req_tag_o   = '0;
    assign scrub_busy_o      = 1'b0;
    assign scrub_drop_o      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tag_ecc_check.sv
`default_nettype none
// ============================================================================
// Module      : tb_tag_ecc_check
// Description : Directed self-checking bench for tag_ecc_check. It checks
//               clean, SBE, DBE, masked-way, multi-SBE/backpressure,
//               reset-during-scrub and counter saturation cases. Scrub
//               payload checks apply when TAG_SCRUB_EN is defined. Otherwise
//               the bench checks that the scrub outputs stay at zero.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tag_ecc_check;

    localparam int WAY_N = 4;
    localparam int IDX_W = 6;
    localparam int TAG_W = 28;
    localparam int ECC_W = 7;

    logic                        clk;
    logic                        rst;
    logic                        lkup_valid;
    logic [IDX_W-1:0]            lkup_idx;
    logic [WAY_N-1:0]            lkup_way;
    logic [WAY_N-1:0][TAG_W-1:0] tag_rd;
    logic [WAY_N-1:0][ECC_W-1:0] ecc_rd;
    logic                        chk_valid;
    logic [WAY_N-1:0][TAG_W-1:0] chk_tag;
    logic [WAY_N-1:0]            chk_sbe;
    logic [WAY_N-1:0]            chk_dbe;
    logic                        s_valid;
    logic                        s_ready;
    logic [IDX_W-1:0]            s_idx;
    logic [WAY_N-1:0]            s_way;
    logic [TAG_W-1:0]            s_tag;
    logic                        s_busy;
    logic                        s_drop;
    logic [15:0]                 sbe_cnt;
    logic [15:0]                 dbe_cnt;

    int checks   = 0;
    int failures = 0;

    tag_ecc_check #(
        .WAY_N (WAY_N),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W),
        .ECC_W (ECC_W)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .lkup_valid_i      (lkup_valid),
        .lkup_idx_i        (lkup_idx),
        .lkup_way_i        (lkup_way),
        .tag_rd_i          (tag_rd),
        .tag_ecc_rd_i      (ecc_rd),
        .chk_valid_o       (chk_valid),
        .chk_tag_o         (chk_tag),
        .chk_sbe_o         (chk_sbe),
        .chk_dbe_o         (chk_dbe),
        .scrub_req_valid_o (s_valid),
        .scrub_req_ready_i (s_ready),
        .scrub_req_idx_o   (s_idx),
        .scrub_req_way_o   (s_way),
        .scrub_req_tag_o   (s_tag),
        .scrub_busy_o      (s_busy),
        .scrub_drop_o      (s_drop),
        .sbe_cnt_o         (sbe_cnt),
        .dbe_cnt_o         (dbe_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference encoder. It walks the codeword and XORs together the
    // position numbers of the set data bits. The check bits then give a
    // zero syndrome.
    function automatic logic [6:0] ref_ecc(input logic [27:0] d);
        logic [5:0] s;
        int         di;
        s  = '0;
        di = 0;
        for (int p = 1; p <= 34; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (d[di]) s = s ^ 6'(p);
                di++;
            end
        end
        return {^{d, s}, s};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [3:0][27:0] t, input logic [3:0][27:0] f,
                        input logic [3:0][6:0] e);
        for (int w = 0; w < 4; w++) begin
            tag_rd[w] = t[w] ^ f[w];
            ecc_rd[w] = ref_ecc(t[w]) ^ e[w];
        end
    endtask

    // Issues a lookup and presents the read data in the following cycle.
    // The task returns at the check point of the result cycle.
    task automatic lookup(input logic [IDX_W-1:0] idx, input logic [3:0] way,
                          input logic [3:0][27:0] t, input logic [3:0][27:0] f,
                          input logic [3:0][6:0] e);
        lkup_valid = 1'b1;
        lkup_idx   = idx;
        lkup_way   = way;
        tick();
        lkup_valid = 1'b0;
        load(t, f, e);
        #1;
    endtask

    logic [3:0][27:0] base;
    logic [3:0][27:0] ft;
    logic [3:0][6:0]  fe;

    initial begin
        rst        = 1'b1;
        lkup_valid = 1'b0;
        lkup_idx   = '0;
        lkup_way   = '0;
        tag_rd     = '0;
        ecc_rd     = '0;
        s_ready    = 1'b0;
        base       = {28'h5A5A5A5, 28'hFEDCBA9, 28'h1234567, 28'h0ABCDEF};
        ft         = '0;
        fe         = '0;

        // ---------------- reset state ----------------
        tick();
        tick();
        check("rst_chk_valid", 128'(chk_valid), 128'(0));
        check("rst_sbe_dbe",   128'({chk_sbe, chk_dbe}), 128'(0));
        check("rst_cnts",      128'({sbe_cnt, dbe_cnt}), 128'(0));
        check("rst_scrub",     128'({s_valid, s_busy, s_drop, s_tag, s_way, s_idx}), 128'(0));
        check("rst_chk_tag",   128'(chk_tag), 128'(0));
        rst = 1'b0;
        tick();

        // ---------------- clean read ----------------
        lookup(6'd5, 4'b0011, base, '0, '0);
        check("clean_valid",   128'(chk_valid), 128'(1));
        check("clean_tag",     128'(chk_tag), 128'(base));
        check("clean_sbe_dbe", 128'({chk_sbe, chk_dbe}), 128'(0));
        tick();
        check("clean_valid_off", 128'(chk_valid), 128'(0));
        check("clean_cnts",      128'({sbe_cnt, dbe_cnt}), 128'(0));
        check("clean_no_scrub",  128'({s_valid, s_busy}), 128'(0));

        // ---------------- SBE, tag bit 3 in way 2 ----------------
        ft    = '0;
        ft[2] = 28'h0000008;
        lookup(6'd5, 4'b1111, base, ft, '0);
        check("sbe_mask", 128'(chk_sbe), 128'(4'b0100));
        check("sbe_dbe",  128'(chk_dbe), 128'(0));
        check("sbe_tag",  128'(chk_tag), 128'(base));
        tick();
        check("sbe_cnt",          128'(sbe_cnt), 128'(1));
        check("sbe_invalid_flag", 128'(chk_sbe), 128'(0));
        check("sbe_invalid_raw",  128'(chk_tag), 128'(base ^ ft));
`ifdef TAG_SCRUB_EN
        check("sbe_scrub_valid", 128'({s_valid, s_busy}), 128'(2'b11));
        check("sbe_scrub_idx",   128'(s_idx), 128'(5));
        check("sbe_scrub_way",   128'(s_way), 128'(4'b0100));
        check("sbe_scrub_tag",   128'(s_tag), 128'(base[2]));
        tick();
        tick();
        check("sbe_scrub_hold", 128'({s_valid, s_way, s_tag}), 128'({1'b1, 4'b0100, base[2]}));
        s_ready = 1'b1;
        tick();
        s_ready = 1'b0;
        check("sbe_scrub_done", 128'({s_valid, s_busy}), 128'(0));
`else
        check("sbe_scrub_off", 128'({s_valid, s_busy, s_tag, s_way, s_idx}), 128'(0));
`endif

        // ---------------- DBE, bits 0 and 27 in way 1 ----------------
        ft    = '0;
        ft[1] = 28'h8000001;
        lookup(6'd7, 4'b1111, base, ft, '0);
        check("dbe_mask", 128'(chk_dbe), 128'(4'b0010));
        check("dbe_sbe",  128'(chk_sbe), 128'(0));
        check("dbe_tag",  128'(chk_tag), 128'(base ^ ft));
        tick();
        check("dbe_cnts",     128'({sbe_cnt, dbe_cnt}), 128'({16'd1, 16'd1}));
        check("dbe_no_scrub", 128'({s_valid, s_busy}), 128'(0));

        // ---------------- error in a way outside the mask ----------------
        ft    = '0;
        ft[3] = 28'h0000400;
        lookup(6'd2, 4'b0111, base, ft, '0);
        check("mask_off_flags", 128'({chk_sbe, chk_dbe}), 128'(0));
        check("mask_off_tag",   128'(chk_tag), 128'(base ^ ft));
        tick();
        check("mask_off_cnt", 128'(sbe_cnt), 128'(1));

        // ---------------- multi-SBE with backpressure ----------------
        ft    = '0;
        ft[3] = 28'h0008000;
        fe    = '0;
        fe[0] = 7'h04;
        lookup(6'd9, 4'b1111, base, ft, fe);
        check("multi_sbe_mask", 128'(chk_sbe), 128'(4'b1001));
        check("multi_tag",      128'(chk_tag), 128'(base));
        check("multi_dbe",      128'(chk_dbe), 128'(0));
        tick();
        check("multi_cnt", 128'(sbe_cnt), 128'(3));
`ifdef TAG_SCRUB_EN
        check("multi_first", 128'({s_valid, s_idx, s_way, s_tag}),
              128'({1'b1, 6'd9, 4'b0001, base[0]}));
`else
        check("multi_off", 128'({s_valid, s_busy}), 128'(0));
`endif
        ft    = '0;
        ft[2] = 28'h0100000;
        lookup(6'd11, 4'b1111, base, ft, '0);
        check("drop_sbe_seen", 128'(chk_sbe), 128'(4'b0100));
`ifdef TAG_SCRUB_EN
        check("drop_pulse", 128'({s_drop, s_busy}), 128'(2'b11));
        check("drop_hold",  128'({s_valid, s_way}), 128'({1'b1, 4'b0001}));
`else
        check("drop_off", 128'(s_drop), 128'(0));
`endif
        tick();
        check("drop_end", 128'(s_drop), 128'(0));
        check("drop_cnt", 128'(sbe_cnt), 128'(4));
`ifdef TAG_SCRUB_EN
        check("bp_hold", 128'({s_valid, s_idx, s_way, s_tag}),
              128'({1'b1, 6'd9, 4'b0001, base[0]}));
        tick();
        check("bp_hold2", 128'({s_valid, s_way}), 128'({1'b1, 4'b0001}));
        s_ready = 1'b1;
        tick();
        check("multi_second", 128'({s_valid, s_idx, s_way, s_tag}),
              128'({1'b1, 6'd9, 4'b1000, base[3]}));
        tick();
        s_ready = 1'b0;
        check("multi_done", 128'({s_valid, s_busy}), 128'(0));
`endif

        // ---------------- reset during a scrub request ----------------
        ft    = '0;
        ft[0] = 28'h0000080;
        lookup(6'd3, 4'b0001, base, ft, '0);
        tick();
`ifdef TAG_SCRUB_EN
        check("rst_pre_valid", 128'(s_valid), 128'(1));
`endif
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_scrub", 128'({s_valid, s_busy, chk_valid}), 128'(0));
        check("rst_mid_cnts",  128'({sbe_cnt, dbe_cnt}), 128'(0));
        tick();
        rst = 1'b0;
        tick();
        check("rst_no_resume", 128'({s_valid, s_busy}), 128'(0));

        // ---------------- counter saturation ----------------
        ft = {4{28'h0000002}};
        load(base, ft, '0);
        lkup_way   = 4'b1111;
        lkup_valid = 1'b1;
        repeat (16383) @(posedge clk);
        #1;
        lkup_valid = 1'b0;
        tick();
        check("sat_pre",     128'(sbe_cnt), 128'(16'hFFFC));
        check("sat_pre_dbe", 128'(dbe_cnt), 128'(0));
        lkup_valid = 1'b1;
        tick();
        lkup_valid = 1'b0;
        tick();
        check("sat_clip", 128'(sbe_cnt), 128'(16'hFFFF));
        lkup_valid = 1'b1;
        tick();
        lkup_valid = 1'b0;
        tick();
        check("sat_hold", 128'(sbe_cnt), 128'(16'hFFFF));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
